mult_div_ctrl: RTL and testbench
================================

Name: mult_div_ctrl

Overview:
- Multicycle sequencer for the CPU's MULT/DIV instructions.
- Owns one shared iterative shift/add datapath. Accepts a start request from the control unit and holds it stalled via busy.
- Produces HI/LO results with a write strobe, plus the select that drives the MULT/DIV hilo mux controls.
- Flags divide-by-zero to the control unit's exception logic.

Parameters:
- DATA_W, 32, operand and result width.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mult_start  in  1  start signed multiply; sampled only in IDLE
- div_start  in  1  start signed divide; sampled only in IDLE
- op_a  in  DATA_W  multiplicand / dividend (register A)
- op_b  in  DATA_W  multiplier / divisor (register B)
- busy  out  1  operation in progress; control unit stalls while high
- done  out  1  one-cycle pulse, result valid
- hilo_write  out  1  one-cycle pulse, load HI/LO registers (equals done)
- hilo_src  out  1  0 = mult result, 1 = div result; drives mult_mux_control/div_mux_control
- hi_out  out  DATA_W  HI result (mult upper word / div remainder)
- lo_out  out  DATA_W  LO result (mult lower word / div quotient)
- div_zero  out  1  one-cycle pulse, divisor was zero

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, hilo_write, hilo_src, div_zero, hi_out, lo_out, counter, internal accumulators all 0.
- States: IDLE, MULT, DIV, DIV_FIX, DONE, DZERO.
- IDLE:
  - mult_start at edge k: latch op_a/op_b, counter=0, hilo_src=0, go MULT.
  - else div_start with op_b!=0: latch magnitudes and signs, hilo_src=1, go DIV.
  - else div_start with op_b==0: go DZERO.
  - mult_start and div_start both high: mult wins, div request dropped.
- MULT: radix-2 Booth, one step per edge, 2*DATA_W-bit product, arithmetic shift right. After step 32 (edge k+32) go DONE.
- DIV: restoring division on unsigned magnitudes, one step per edge. After step 32 (edge k+32) go DIV_FIX.
- DIV_FIX: one edge (k+33) applying signs, then go DONE.
  - Quotient negated iff operand signs differ.
  - Remainder takes the dividend's sign.
  - -2^31 / -1 yields LO=0x80000000, HI=0 (wraps, no trap).
- DONE: one cycle; done=hilo_write=1; hi_out/lo_out valid. Next edge goes IDLE.
  - Mult: done visible in cycle after edge k+32.
  - Div: done visible in cycle after edge k+33.
- DZERO: one cycle; div_zero=1, busy=1, no hilo_write, hi_out/lo_out unchanged. Next edge goes IDLE.
- busy=1 in every state except IDLE (registered, high from cycle after edge k).
- Start signals while busy are ignored, not queued.
- hi_out/lo_out are registered and hold the last completed result until the next DONE.
- hilo_src holds its value until the next accepted start.
- Reset mid-operation: abort, all outputs to reset values, no hilo_write; next start behaves normally.

Decomposition:
- Shared package mips_pkg:
  - md_state_t enum (IDLE, MULT, DIV, DIV_FIX, DONE, DZERO)
  - HILO_SRC_MULT=1'b0, HILO_SRC_DIV=1'b1
  - DATA_W default
- One sub-module: md_step_unit. Combinational single iteration, selected by mode:
  - Booth add/sub/shift
  - restoring subtract/shift
- mult_div_ctrl keeps FSM, counter and registers.

Test Plan:
- mult op_a=7, op_b=0xFFFFFFFD (-3) -> done/hilo_write in cycle after edge k+32; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, hilo_src=0, busy high cycles k+1..k+33.
- div op_a=0xFFFFFFF9 (-7), op_b=2 -> done in cycle after edge k+33; lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1), hilo_src=1.
- mult 0x80000000 × 0x80000000 -> hi_out=0x40000000, lo_out=0x00000000; then div 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- div op_b=0 after a prior mult result -> div_zero pulse in cycle after edge k, busy high that cycle only, no hilo_write, hi_out/lo_out retain prior values.
- mult_start and div_start together (6, 5) -> mult performed, lo_out=30, hilo_src=0; div_start pulsed at step 10 -> ignored, single done pulse.
- reset asserted at step 10 of mult 0x1234×0x10 -> all outputs 0 immediately, no done; after release, mult 3×4 -> lo_out=12, done at edge+32 timing.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MULT/DIV sequencer: state encoding, HI/LO mux
// select values and the default datapath width.
package mips_pkg;

    localparam int DEFAULT_DATA_W = 32;

    localparam logic HILO_SRC_MULT = 1'b0;
    localparam logic HILO_SRC_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        DIV_FIX,
        DONE,
        DZERO
    } md_state_t;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Request/result bundle between the control unit (master) and the
// MULT/DIV sequencer (slave).
interface mult_div_ctrl_if
    import mips_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              mult_start;
    logic              div_start;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              busy;
    logic              done;
    logic              hilo_write;
    logic              hilo_src;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              div_zero;

    modport master (
        output mult_start, div_start, op_a, op_b,
        input  busy, done, hilo_write, hilo_src, hi_out, lo_out, div_zero
    );

    modport slave (
        input  mult_start, div_start, op_a, op_b,
        output busy, done, hilo_write, hilo_src, hi_out, lo_out, div_zero
    );
endinterface

// File: rtl/md_step_unit.sv
// One iteration of the shared shift/add datapath.
// mode_div = 0: radix-2 Booth step on {acc, q, qm1}, multiplicand in m_in.
// mode_div = 1: restoring-division step on {acc (remainder), q (dividend /
//               quotient)}, divisor magnitude in m_in.
// acc carries one guard bit so Booth add/sub of -2^(W-1) cannot overflow.
module md_step_unit #(
    parameter int DATA_W = 32
) (
    input  logic              mode_div,
    input  logic [DATA_W:0]   acc_in,
    input  logic [DATA_W-1:0] q_in,
    input  logic              qm1_in,
    input  logic [DATA_W-1:0] m_in,
    output logic [DATA_W:0]   acc_out,
    output logic [DATA_W-1:0] q_out,
    output logic              qm1_out
);
    logic [DATA_W:0] m_ext;
    logic [DATA_W:0] booth_sum;
    logic [DATA_W:0] rem_sh;
    logic [DATA_W:0] trial;

    // Single combinational iteration for whichever operation is active.
    always_comb begin
        m_ext     = {m_in[DATA_W-1], m_in};
        booth_sum = acc_in;
        rem_sh    = {acc_in[DATA_W-1:0], q_in[DATA_W-1]};
        trial     = rem_sh - {1'b0, m_in};
        acc_out   = acc_in;
        q_out     = q_in;
        qm1_out   = 1'b0;
        if (!mode_div) begin
            case ({q_in[0], qm1_in})
                2'b01:   booth_sum = acc_in + m_ext;
                2'b10:   booth_sum = acc_in - m_ext;
                default: booth_sum = acc_in;
            endcase
            acc_out = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
            q_out   = {booth_sum[0], q_in[DATA_W-1:1]};
            qm1_out = q_in[0];
        end else begin
            if (!trial[DATA_W]) begin
                acc_out = trial;
                q_out   = {q_in[DATA_W-2:0], 1'b1};
            end else begin
                acc_out = rem_sh;
                q_out   = {q_in[DATA_W-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/mult_div_ctrl.sv
// Multicycle MULT/DIV sequencer: accepts a start while idle, iterates the
// shared step unit DATA_W times, then writes HI/LO with a one-cycle strobe.
// Divide-by-zero is reported with a one-cycle div_zero pulse and no write.
//
// state   | meaning
// IDLE    | waiting for mult_start / div_start
// MULT    | Booth iterations, one per clock
// DIV     | restoring-division iterations on magnitudes, one per clock
// DIV_FIX | apply quotient/remainder signs, load HI/LO
// DONE    | result valid, done = hilo_write = 1
// DZERO   | divisor was zero, div_zero = 1, HI/LO untouched
module mult_div_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic clk,
    input  logic reset,
    mult_div_ctrl_if.slave md
);
    md_state_t         state;
    md_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] q_reg;
    logic [DATA_W-1:0] m_reg;
    logic              qm1;
    logic              sign_a;
    logic              sign_b;
    logic [DATA_W-1:0] hi_reg;
    logic [DATA_W-1:0] lo_reg;
    logic              src_reg;

    logic [DATA_W:0]   step_acc;
    logic [DATA_W-1:0] step_q;
    logic              step_qm1;
    logic              last_step;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] quot_fix;
    logic [DATA_W-1:0] rem_fix;
    logic              busy_c;
    logic              done_c;
    logic              dz_c;

    assign last_step = (cnt == CNT_W'(DATA_W - 1));
    assign mag_a     = md.op_a[DATA_W-1] ? -md.op_a : md.op_a;
    assign mag_b     = md.op_b[DATA_W-1] ? -md.op_b : md.op_b;
    assign quot_fix  = (sign_a ^ sign_b) ? -q_reg : q_reg;
    assign rem_fix   = sign_a ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];

    md_step_unit #(.DATA_W(DATA_W)) u_step (
        .mode_div (state == DIV),
        .acc_in   (acc),
        .q_in     (q_reg),
        .qm1_in   (qm1),
        .m_in     (m_reg),
        .acc_out  (step_acc),
        .q_out    (step_q),
        .qm1_out  (step_qm1)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; mult wins when both starts arrive together.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (md.mult_start)     state_nxt = MULT;
                else if (md.div_start) state_nxt = (md.op_b == '0) ? DZERO : DIV;
            end
            MULT:    if (last_step) state_nxt = DONE;
            DIV:     if (last_step) state_nxt = DIV_FIX;
            DIV_FIX: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            DZERO:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy_c = (state != IDLE);
        done_c = (state == DONE);
        dz_c   = (state == DZERO);
    end

    // Operand latch, iteration registers and HI/LO result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            qm1     <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            src_reg <= HILO_SRC_MULT;
        end else begin
            case (state)
                IDLE: begin
                    if (md.mult_start) begin
                        cnt     <= '0;
                        acc     <= '0;
                        q_reg   <= md.op_b;
                        m_reg   <= md.op_a;
                        qm1     <= 1'b0;
                        src_reg <= HILO_SRC_MULT;
                    end else if (md.div_start && (md.op_b != '0)) begin
                        cnt     <= '0;
                        acc     <= '0;
                        q_reg   <= mag_a;
                        m_reg   <= mag_b;
                        qm1     <= 1'b0;
                        sign_a  <= md.op_a[DATA_W-1];
                        sign_b  <= md.op_b[DATA_W-1];
                        src_reg <= HILO_SRC_DIV;
                    end
                end
                MULT, DIV: begin
                    acc   <= step_acc;
                    q_reg <= step_q;
                    qm1   <= step_qm1;
                    cnt   <= cnt + CNT_W'(1);
                    if ((state == MULT) && last_step) begin
                        hi_reg <= step_acc[DATA_W-1:0];
                        lo_reg <= step_q;
                    end
                end
                DIV_FIX: begin
                    hi_reg <= rem_fix;
                    lo_reg <= quot_fix;
                end
                default: ;
            endcase
        end
    end

    assign md.busy       = busy_c;
    assign md.done       = done_c;
    assign md.hilo_write = done_c;
    assign md.div_zero   = dz_c;
    assign md.hilo_src   = src_reg;
    assign md.hi_out     = hi_reg;
    assign md.lo_out     = lo_reg;
endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_ctrl;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_ctrl_if #(.DATA_W(DW)) md_bus ();

    mult_div_ctrl #(.DATA_W(DW), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_hi  = '0;
    logic [31:0] exp_lo  = '0;
    logic        exp_src = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // kind: 0 = mult, 1 = div, 2 = both starts (mult wins). Returns 1 for div-by-zero.
    task automatic model_op(input int kind, input logic [31:0] a, input logic [31:0] b, output bit dz);
        longint sa, sb, p, qq, rr;
        dz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (kind == 1 && b == 32'h0) begin
            dz = 1'b1;
        end else if (kind != 1) begin
            p       = sa * sb;
            exp_hi  = p[63:32];
            exp_lo  = p[31:0];
            exp_src = 1'b0;
        end else begin
            qq      = sa / sb;
            rr      = sa % sb;
            exp_lo  = qq[31:0];
            exp_hi  = rr[31:0];
            exp_src = 1'b1;
        end
    endtask

    task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                          input int inject_n, input string tag);
        logic [31:0] prev_hi, prev_lo;
        bit dz;
        int done_at, dz_at, end_n, n_done, hw_mis;
        prev_hi = exp_hi;
        prev_lo = exp_lo;
        done_at = 0; dz_at = 0; end_n = 0; n_done = 0; hw_mis = 0;
        model_op(kind, a, b, dz);

        @(negedge clk);
        md_bus.op_a       = a;
        md_bus.op_b       = b;
        md_bus.mult_start = (kind != 1);
        md_bus.div_start  = (kind != 0);
        @(posedge clk);
        @(negedge clk);
        md_bus.mult_start = 1'b0;
        md_bus.div_start  = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 1)
                check_val({tag, "/hold"}, {md_bus.hi_out, md_bus.lo_out}, {prev_hi, prev_lo});
            if (md_bus.done !== md_bus.hilo_write) hw_mis++;
            if (md_bus.done === 1'b1) begin
                n_done++;
                if (done_at == 0) done_at = n;
            end
            if (md_bus.div_zero === 1'b1 && dz_at == 0) dz_at = n;
            if (md_bus.busy !== 1'b1) begin
                end_n = n;
                break;
            end
            // ops change after the start edge must not disturb the operation
            md_bus.op_a      = $urandom;
            md_bus.op_b      = $urandom;
            md_bus.div_start = (n == inject_n);
            @(negedge clk);
        end
        md_bus.div_start = 1'b0;

        if (dz) begin
            check_val({tag, "/dz_at"},  dz_at,  1);
            check_val({tag, "/dz_nodone"}, n_done, 0);
            check_val({tag, "/dz_end"}, end_n,  2);
        end else begin
            check_val({tag, "/done_at"}, done_at, (kind == 1) ? 34 : 33);
            check_val({tag, "/n_done"},  n_done,  1);
            check_val({tag, "/end"},     end_n,   (kind == 1) ? 35 : 34);
            check_val({tag, "/no_dz"},   dz_at,   0);
        end
        check_val({tag, "/hw_eq_done"}, hw_mis, 0);
        check_val({tag, "/hilo"}, {md_bus.hi_out, md_bus.lo_out}, {exp_hi, exp_lo});
        check_val({tag, "/src"},  md_bus.hilo_src, exp_src);
    endtask

    logic [31:0] corners [6];
    logic [31:0] ra, rb;
    int          rk, n_done_rst;

    initial begin
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h2;

        reset             = 1'b1;
        md_bus.mult_start = 1'b0;
        md_bus.div_start  = 1'b0;
        md_bus.op_a       = '0;
        md_bus.op_b       = '0;
        repeat (3) @(negedge clk);
        check_val("rst_flags", {md_bus.busy, md_bus.done, md_bus.hilo_write,
                                md_bus.hilo_src, md_bus.div_zero}, 5'b0);
        check_val("rst_hilo", {md_bus.hi_out, md_bus.lo_out}, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op(0, 32'd7, 32'hFFFF_FFFD, 0, "mult_7x-3");
        run_op(1, 32'hFFFF_FFF9, 32'd2, 0, "div_-7/2");
        run_op(0, 32'h8000_0000, 32'h8000_0000, 0, "mult_min2");
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min/-1");
        run_op(0, 32'h1234_5678, 32'd9, 0, "mult_pre_dz");
        run_op(1, 32'd55, 32'h0, 0, "div_zero");
        run_op(2, 32'd6, 32'd5, 10, "both_6_5");

        for (int i = 0; i < 24; i++) begin
            rk = $urandom_range(0, 2);
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 1) == 1) rb = $urandom_range(0, 300) - 150;
            run_op(rk, ra, rb, $urandom_range(0, 30), $sformatf("rnd%0d", i));
        end

        run_op(1, 32'd100, 32'd7, 0, "div_pre_rst");

        @(negedge clk);
        md_bus.op_a       = 32'h1234;
        md_bus.op_b       = 32'h10;
        md_bus.mult_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        md_bus.mult_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("midrst_flags", {md_bus.busy, md_bus.done, md_bus.hilo_write,
                                   md_bus.hilo_src, md_bus.div_zero}, 5'b0);
        check_val("midrst_hilo", {md_bus.hi_out, md_bus.lo_out}, 64'h0);
        exp_hi  = '0;
        exp_lo  = '0;
        exp_src = 1'b0;
        n_done_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (md_bus.done === 1'b1 || md_bus.hilo_write === 1'b1) n_done_rst++;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (md_bus.done === 1'b1 || md_bus.hilo_write === 1'b1) n_done_rst++;
        end
        check_val("midrst_nodone", n_done_rst, 0);
        check_val("midrst_idle", md_bus.busy, 1'b0);

        run_op(0, 32'd3, 32'd4, 0, "mult_3x4");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
